fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fetch_unit                                                  |
// | Purpose  : Instruction fetch sequencer. Requests one 9-bit word per    |
// |            instruction, holds it for decode until retired, then        |
// |            resolves halt/jump/branch redirects for one cycle.          |
// | Options  : FETCH_RETIRE_CNT_EN adds a saturating 16-bit retire counter.|
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module fetch_unit #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [8:0]      imem_data,
   output logic            instr_valid,
   output logic            format,
   output logic [3:0]      opcode,
   output logic            sign,
   output logic [3:0]      operand,
   input  logic            stall,
   input  logic            branch,
   input  logic            jump,
   input  logic            halt,
   input  logic            cond,
   input  logic [PC_W-1:0] target,
`ifdef FETCH_RETIRE_CNT_EN
   output logic [15:0]     retire_cnt,
`endif
   output logic [PC_W-1:0] pc,
   output logic            halted
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_RESOLVE = 3'd3,
      ST_HALTED  = 3'd4
   } state_t;

   localparam logic [PC_W-1:0] C_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [8:0]      instr_q, instr_d;
   logic            req_q, req_d;
   logic            valid_q, valid_d;
   logic            halted_q, halted_d;
   logic            w_retire;
`ifdef FETCH_RETIRE_CNT_EN
   logic [15:0]     retire_cnt_q, retire_cnt_d;
`endif

   // Next-state, PC and instruction register; outputs are derived from the
   // next state so they are registered alongside it.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      w_retire = 1'b0;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_data;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!stall) begin
               w_retire = 1'b1;
               state_d  = ST_RESOLVE;
            end
         end
         ST_RESOLVE: begin
            if (halt) begin
               state_d = ST_HALTED;
            end else begin
               state_d = ST_FETCH;
               if (jump || (branch && cond)) begin
                  pc_d = target;
               end else begin
                  pc_d = pc_q + C_PC_ONE;
               end
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase
      req_d    = (state_d == ST_FETCH);
      valid_d  = (state_d == ST_ISSUE);
      halted_d = (state_d == ST_HALTED);
   end

`ifdef FETCH_RETIRE_CNT_EN
   // Retire counter sticks at all-ones instead of wrapping.
   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (w_retire && (retire_cnt_q != 16'hFFFF)) begin
         retire_cnt_d = retire_cnt_q + 16'd1;
      end
   end
`endif

   // State register; reset overrides everything, including a pending ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
`ifdef FETCH_RETIRE_CNT_EN
         retire_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         req_q    <= req_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
`ifdef FETCH_RETIRE_CNT_EN
         retire_cnt_q <= retire_cnt_d;
`endif
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr_valid = valid_q;
   assign halted      = halted_q;
   assign format      = instr_q[8];
   assign opcode      = instr_q[7:4];
   assign sign        = instr_q[3];
   assign operand     = instr_q[3:0];
`ifdef FETCH_RETIRE_CNT_EN
   assign retire_cnt  = retire_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                               |
// | Purpose  : Directed self-checking bench for fetch_unit.                |
// | Options  : FETCH_RETIRE_CNT_EN enables the retire counter checks.      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack = 1'b0;
   logic [8:0] imem_data = '0;
   logic       instr_valid;
   logic       format;
   logic [3:0] opcode;
   logic       sign;
   logic [3:0] operand;
   logic       stall = 1'b0;
   logic       branch = 1'b0;
   logic       jump = 1'b0;
   logic       halt = 1'b0;
   logic       cond = 1'b0;
   logic [7:0] target = '0;
   logic [7:0] pc;
   logic       halted;
`ifdef FETCH_RETIRE_CNT_EN
   logic [15:0] retire_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_data  (imem_data),
      .instr_valid(instr_valid),
      .format     (format),
      .opcode     (opcode),
      .sign       (sign),
      .operand    (operand),
      .stall      (stall),
      .branch     (branch),
      .jump       (jump),
      .halt       (halt),
      .cond       (cond),
      .target     (target),
`ifdef FETCH_RETIRE_CNT_EN
      .retire_cnt (retire_cnt),
`endif
      .pc         (pc),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_chk++;
      assert (obs === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Starting in FETCH: deliver one word, retire it, apply redirects in RESOLVE.
   task automatic issue_one(input string tag, input logic [8:0] w,
                            input logic br, input logic cd, input logic jp,
                            input logic ht, input logic [7:0] tgt,
                            input logic [7:0] exp_addr);
      chk({tag, "_req"}, {15'd0, imem_req}, 16'd1);
      imem_data = w;
      imem_ack  = 1'b1;
      tick();
      imem_ack  = 1'b0;
      chk({tag, "_valid"}, {15'd0, instr_valid}, 16'd1);
      chk({tag, "_opcode"}, {12'd0, opcode}, {12'd0, w[7:4]});
      tick();
      chk({tag, "_resolve"}, {15'd0, instr_valid}, 16'd0);
      branch = br;
      cond   = cd;
      jump   = jp;
      halt   = ht;
      target = tgt;
      tick();
      branch = 1'b0;
      cond   = 1'b0;
      jump   = 1'b0;
      halt   = 1'b0;
      chk({tag, "_addr"}, {8'd0, imem_addr}, {8'd0, exp_addr});
      chk({tag, "_req2"}, {15'd0, imem_req}, {15'd0, ~ht});
      chk({tag, "_halted"}, {15'd0, halted}, {15'd0, ht});
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_req", {15'd0, imem_req}, 16'd0);
      chk("rst_valid", {15'd0, instr_valid}, 16'd0);
      chk("rst_halted", {15'd0, halted}, 16'd0);
      chk("rst_pc", {8'd0, pc}, 16'h0000);
      reset = 1'b0;
      chk("idle_req", {15'd0, imem_req}, 16'd0);
      tick();
      chk("fetch0_req", {15'd0, imem_req}, 16'd1);
      chk("fetch0_addr", {8'd0, imem_addr}, 16'h0000);
      chk("fetch0_valid", {15'd0, instr_valid}, 16'd0);

      // Zero-wait ack of 9'h1A3
      imem_data = 9'h1A3;
      imem_ack  = 1'b1;
      tick();
      imem_ack  = 1'b0;
      chk("w0_valid", {15'd0, instr_valid}, 16'd1);
      chk("w0_format", {15'd0, format}, 16'd1);
      chk("w0_opcode", {12'd0, opcode}, 16'hA);
      chk("w0_sign", {15'd0, sign}, 16'd0);
      chk("w0_operand", {12'd0, operand}, 16'h3);
      tick();
      chk("w0_resolve_valid", {15'd0, instr_valid}, 16'd0);
      chk("w0_resolve_req", {15'd0, imem_req}, 16'd0);
      tick();
      chk("fetch1_req", {15'd0, imem_req}, 16'd1);
      chk("fetch1_addr", {8'd0, imem_addr}, 16'h0001);

      // 9'h0F0 with three stall cycles
      imem_data = 9'h0F0;
      imem_ack  = 1'b1;
      tick();
      imem_ack  = 1'b0;
      chk("w1_valid", {15'd0, instr_valid}, 16'd1);
      chk("w1_format", {15'd0, format}, 16'd0);
      chk("w1_opcode", {12'd0, opcode}, 16'hF);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_valid", {15'd0, instr_valid}, 16'd1);
         chk("stall_opcode", {12'd0, opcode}, 16'hF);
         chk("stall_format", {15'd0, format}, 16'd0);
      end
      stall = 1'b0;
      tick();
      chk("stall_resolve", {15'd0, instr_valid}, 16'd0);
      tick();
      chk("stall_next_req", {15'd0, imem_req}, 16'd1);
      chk("stall_next_addr", {8'd0, imem_addr}, 16'h0002);

      // Redirects
      issue_one("br_nt", 9'h021, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 8'h03);
      issue_one("br_t", 9'h032, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40, 8'h40);
      issue_one("jmp_br", 9'h043, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 8'h80);

      // Redirect and ack during ISSUE are ignored
      imem_data = 9'h155;
      imem_ack  = 1'b1;
      tick();
      imem_data = 9'h0E0;
      jump      = 1'b1;
      target    = 8'h10;
      stall     = 1'b1;
      tick();
      chk("iss_ack_ign_opcode", {12'd0, opcode}, 16'h5);
      chk("iss_ack_ign_valid", {15'd0, instr_valid}, 16'd1);
      imem_ack  = 1'b0;
      jump      = 1'b0;
      stall     = 1'b0;
      tick();
      tick();
      chk("iss_jmp_ign_addr", {8'd0, imem_addr}, 16'h0081);

      // Wrap at all-ones
      issue_one("jmp_ff", 9'h066, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
      issue_one("wrap", 9'h077, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      // Halt beats jump; remains halted with acks present
      issue_one("halt", 9'h1FF, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h00);
      imem_ack = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("halted_req", {15'd0, imem_req}, 16'd0);
         chk("halted_flag", {15'd0, halted}, 16'd1);
         chk("halted_valid", {15'd0, instr_valid}, 16'd0);
      end
      imem_ack = 1'b0;
      reset = 1'b1;
      tick();
      chk("hrst_addr", {8'd0, imem_addr}, 16'h0000);
      chk("hrst_halted", {15'd0, halted}, 16'd0);
      chk("hrst_opcode", {12'd0, opcode}, 16'h0);
      chk("hrst_format", {15'd0, format}, 16'd0);
      reset = 1'b0;
      tick();
      chk("hrst_fetch_req", {15'd0, imem_req}, 16'd1);

      // Reset during outstanding fetch, stale ack afterwards
      reset = 1'b1;
      tick();
      chk("frst_req", {15'd0, imem_req}, 16'd0);
      reset     = 1'b0;
      imem_data = 9'h1FF;
      imem_ack  = 1'b1;
      tick();
      imem_ack  = 1'b0;
      chk("stale_valid", {15'd0, instr_valid}, 16'd0);
      chk("stale_req", {15'd0, imem_req}, 16'd1);
      chk("stale_addr", {8'd0, imem_addr}, 16'h0000);
      tick();
      chk("stale_hold_valid", {15'd0, instr_valid}, 16'd0);
      chk("stale_hold_req", {15'd0, imem_req}, 16'd1);

      // Five sequential retires
      for (int i = 0; i < 5; i++) begin
         logic [7:0] nxt;
         nxt = 8'(i + 1);
         issue_one("seq", 9'h0C0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, nxt);
      end
`ifdef FETCH_RETIRE_CNT_EN
      chk("retire_cnt", retire_cnt, 16'd5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
